fetch_queue: RTL and testbench

Instruction fetch stage sitting directly upstream of the single-cycle MIPS datapath: it reads 32-bit words from instruction memory over a request/acknowledge port and buffers them with their PCs in a small FIFO. The datapath consumes words through a valid/ready handshake and steers fetch with a redirect input for taken branches and jumps. Memory latency is thereby decoupled from execution, and a redirect flushes wrong-path words.

---
 rtl/fetch_queue.sv | 146 ++++++++++++++
 tb/tb_fetch_queue.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues word fetches over a req/ack port and buffers {instr, pc}
// in a DEPTH-entry FIFO. Optional counters are enabled with `define FETCHQ_STATS_EN.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [31:0]                redirect_addr,
    output logic                       instr_valid,
    output logic [31:0]                instr,
    output logic [31:0]                instr_pc,
    input  logic                       instr_ready,
`ifdef FETCHQ_STATS_EN
    output logic [31:0]                fetched_cnt,
    output logic [31:0]                discarded_cnt,
`endif
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       hold_addr_q, hold_addr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CntW-1:0]   cnt_after;
    logic [31:0]       instr_mem_q [DEPTH];
    logic [31:0]       pc_mem_q    [DEPTH];
    logic              push, pop;

    assign imem_req    = (state_q != StIdle);
    // While discarding, the old request must stay on the bus until its ack returns.
    assign imem_addr   = (state_q == StDiscard) ? hold_addr_q : pc_q;
    assign instr_valid = (cnt_q != '0);
    assign instr       = instr_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
    assign instr_pc    = instr_valid ? pc_mem_q[rd_ptr_q] : 32'h0;
    assign occupancy   = cnt_q;

    assign push      = (state_q == StReq) && imem_ack && !redirect;
    assign pop       = instr_valid && instr_ready && !redirect;
    assign cnt_after = cnt_q + CntW'(push) - CntW'(pop);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_addr_d = hold_addr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        if (redirect) begin
            pc_d     = {redirect_addr[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
            unique case (state_q)
                StReq: begin
                    if (imem_ack) begin
                        state_d = StReq;
                    end else begin
                        state_d     = StDiscard;
                        hold_addr_d = pc_q;
                    end
                end
                StDiscard: state_d = imem_ack ? StReq : StDiscard;
                default:   state_d = StReq;
            endcase
        end else begin
            cnt_d    = cnt_after;
            rd_ptr_d = rd_ptr_q + PtrW'(pop);
            wr_ptr_d = wr_ptr_q + PtrW'(push);
            unique case (state_q)
                StIdle: begin
                    if (cnt_after < CntW'(DEPTH)) state_d = StReq;
                end
                StReq: begin
                    if (imem_ack) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = (cnt_after < CntW'(DEPTH)) ? StReq : StIdle;
                    end
                end
                StDiscard: begin
                    if (imem_ack) state_d = StReq;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            hold_addr_q <= 32'h0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_addr_q <= hold_addr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= pc_q;
        end
    end

`ifdef FETCHQ_STATS_EN
    logic [31:0] fetched_q, discarded_q;
    logic        drop_ack;

    // A flush discards every held entry plus any ack arriving in that cycle.
    assign drop_ack = imem_ack && ((state_q == StDiscard) || (redirect && state_q == StReq));

    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q   <= 32'h0;
            discarded_q <= 32'h0;
        end else begin
            fetched_q   <= fetched_q + 32'(push);
            discarded_q <= discarded_q + 32'(drop_ack) + (redirect ? 32'(cnt_q) : 32'h0);
        end
    end

    assign fetched_cnt   = fetched_q;
    assign discarded_cnt = discarded_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: latency-randomized memory and a transaction-level queue model.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [2:0]  occupancy;
`ifdef FETCHQ_STATS_EN
    logic [31:0] fetched_cnt;
    logic [31:0] discarded_cnt;
`endif

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready),
`ifdef FETCHQ_STATS_EN
        .fetched_cnt  (fetched_cnt),
        .discarded_cnt(discarded_cnt),
`endif
        .occupancy    (occupancy)
    );

    int checks = 0;
    int failures = 0;

    // Model: expected queue contents, expected next fetch PC, and one in-flight memory request.
    logic [31:0] q_data[$];
    logic [31:0] q_pc[$];
    logic [31:0] addr_log[$];
    logic [31:0] fpc;
    bit          inflight;
    logic [31:0] infl_addr;
    int          infl_epoch, epoch, lat;
    int          lat_lo = 1, lat_hi = 3;
    bit          prev_req;
    int          idle_run, m_fetched, m_discarded, acks_since_reset;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rdy, input int redir_mode, input logic [31:0] tgt,
                        output bit did_redir);
        bit ack;
        bit do_redir;
        int lo, hi;
        if (!inflight && imem_req) begin
            chk("req_addr", imem_addr, fpc);
            chk("issue_room", 32'(q_data.size() < DEPTH), 32'd1);
            inflight   = 1'b1;
            infl_addr  = imem_addr;
            infl_epoch = epoch;
            lo = lat_lo;
            if (!prev_req && lo < 1) lo = 1;
            hi = (lat_hi < lo) ? lo : lat_hi;
            lat = int'($urandom_range(hi, lo));
            addr_log.push_back(imem_addr);
        end else if (inflight) begin
            chk("req_held", 32'(imem_req), 32'd1);
            chk("addr_stable", imem_addr, infl_addr);
        end
        prev_req = imem_req;
        ack = inflight && (lat == 0);
        if (inflight && lat > 0) lat--;
        do_redir = (redir_mode == 1) || (redir_mode == 2 && ack);

        if (!inflight && !imem_req && q_data.size() < DEPTH) idle_run++;
        else idle_run = 0;
        chk("no_stall", 32'(idle_run <= 1), 32'd1);

        imem_ack      = ack;
        imem_rdata    = ack ? mem_word(infl_addr) : $urandom();
        instr_ready   = rdy;
        redirect      = do_redir;
        redirect_addr = do_redir ? tgt : $urandom();
        #1;
        chk("occupancy", 32'(occupancy), 32'(q_data.size()));
        chk("instr_valid", 32'(instr_valid), 32'(q_data.size() > 0));
        if (q_data.size() > 0) begin
            chk("instr", instr, q_data[0]);
            chk("instr_pc", instr_pc, q_pc[0]);
        end
`ifdef FETCHQ_STATS_EN
        chk("fetched_cnt", fetched_cnt, 32'(m_fetched));
        chk("discarded_cnt", discarded_cnt, 32'(m_discarded));
`endif
        if (ack) acks_since_reset++;
        if (do_redir) begin
            m_discarded += q_data.size() + int'(ack);
            q_data.delete();
            q_pc.delete();
            fpc = tgt & 32'hFFFF_FFFC;
            epoch++;
        end else begin
            if (rdy && q_data.size() > 0) begin
                void'(q_data.pop_front());
                void'(q_pc.pop_front());
            end
            if (ack) begin
                if (infl_epoch == epoch) begin
                    q_data.push_back(mem_word(infl_addr));
                    q_pc.push_back(infl_addr);
                    fpc = infl_addr + 32'd4;
                    m_fetched++;
                end else begin
                    m_discarded++;
                end
            end
        end
        if (ack) inflight = 1'b0;
        did_redir = do_redir;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset       = 1'b1;
        imem_ack    = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("rst_req", 32'(imem_req), 32'd0);
            chk("rst_occ", 32'(occupancy), 32'd0);
            chk("rst_valid", 32'(instr_valid), 32'd0);
        end
        reset = 1'b0;
        q_data.delete();
        q_pc.delete();
        fpc = RST_PC;
        inflight = 1'b0;
        prev_req = 1'b0;
        idle_run = 0;
        m_fetched = 0;
        m_discarded = 0;
        acks_since_reset = 0;
        epoch++;
        chk("post_rst_req", 32'(imem_req), 32'd0);
        chk("post_rst_valid", 32'(instr_valid), 32'd0);
        chk("post_rst_occ", 32'(occupancy), 32'd0);
        chk("post_rst_instr", instr, 32'd0);
        chk("post_rst_pc", instr_pc, 32'd0);
    endtask

    initial begin
        bit d;
        int guard;
        reset = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        redirect = 1'b0;
        redirect_addr = 32'h0;
        instr_ready = 1'b0;
        epoch = 0;
        @(posedge clk);
        #1;
        do_reset(3);

        // Streaming with a one-cycle memory.
        lat_lo = 0; lat_hi = 0;
        repeat (14) step(1'b1, 0, 32'h0, d);
        chk("stream_words", 32'(m_fetched >= 10), 32'd1);

        // Fill with no consumer, then drain.
        do_reset(1);
        repeat (16) step(1'b0, 0, 32'h0, d);
        chk("full_occ", 32'(occupancy), 32'd4);
        chk("full_req", 32'(imem_req), 32'd0);
        chk("full_acks", 32'(acks_since_reset), 32'd4);
        addr_log.delete();
        repeat (12) step(1'b1, 0, 32'h0, d);
        chk("resume_addr", (addr_log.size() > 0) ? addr_log[0] : 32'hDEAD_BEEF, 32'h10);

        // Redirect while 3 entries are held and the request to 12 is outstanding.
        do_reset(1);
        lat_lo = 2; lat_hi = 2;
        guard = 0;
        while (!(q_data.size() == 3 && inflight && lat >= 1) && guard < 60) begin
            step(1'b0, 0, 32'h0, d);
            guard++;
        end
        chk("redir_setup", 32'(guard < 60), 32'd1);
        chk("redir_old_addr", infl_addr, 32'hC);
        step(1'b0, 1, 32'h0000_0043, d);
        addr_log.delete();
        repeat (12) step(1'b1, 0, 32'h0, d);
        chk("redir_new_addr", (addr_log.size() > 0) ? addr_log[0] : 32'hDEAD_BEEF, 32'h40);

        // Redirect coinciding with an ack.
        lat_lo = 1; lat_hi = 3;
        d = 1'b0;
        guard = 0;
        while (!d && guard < 60) begin
            step(1'($urandom_range(1, 0)), 2, 32'h0000_0200, d);
            guard++;
        end
        chk("redir_ack_seen", 32'(d), 32'd1);
        addr_log.delete();
        repeat (10) step(1'b1, 0, 32'h0, d);
        chk("redir_ack_addr", (addr_log.size() > 0) ? addr_log[0] : 32'hDEAD_BEEF, 32'h200);

        // Address wrap through the top of memory.
        lat_lo = 0; lat_hi = 0;
        step(1'b1, 1, 32'hFFFF_FFFB, d);
        addr_log.delete();
        repeat (10) step(1'b1, 0, 32'h0, d);
        chk("wrap_a0", (addr_log.size() > 2) ? addr_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
        chk("wrap_a1", (addr_log.size() > 2) ? addr_log[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        chk("wrap_a2", (addr_log.size() > 2) ? addr_log[2] : 32'hDEAD_BEEF, 32'h0000_0000);

        // Reset while discarding.
        lat_lo = 3; lat_hi = 3;
        guard = 0;
        while (!(inflight && lat >= 2) && guard < 40) begin
            step(1'b0, 0, 32'h0, d);
            guard++;
        end
        chk("disc_setup", 32'(guard < 40), 32'd1);
        step(1'b0, 1, 32'h0000_0100, d);
        step(1'b0, 0, 32'h0, d);
        do_reset(1);
        addr_log.delete();
        lat_lo = 0; lat_hi = 2;
        repeat (8) step(1'b1, 0, 32'h0, d);
        chk("disc_restart", (addr_log.size() > 0) ? addr_log[0] : 32'hDEAD_BEEF, RST_PC);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if (i % 200 == 0) begin
                lat_lo = int'($urandom_range(1, 0));
                lat_hi = lat_lo + int'($urandom_range(3, 0));
            end
            step(1'($urandom_range(3, 0) != 0), ($urandom_range(24, 0) == 0) ? 1 : 0,
                 $urandom(), d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
